if_stage: RTL and testbench



---
 rtl/core_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 23 ++
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the pipelined MIPS core
package core_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{NOP_INSTR, 32'h0000_0000, 1'b0};

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, flush-to-bubble and hold
module if_id_reg
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, single-outstanding imem handshake, IF/ID load
module if_stage
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc4_o,
    output logic        id_valid_o
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q;
    logic        buf_capture;
    logic        ifid_load, ifid_flush;
    if_id_t      ifid_d, ifid_q;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc4;

    assign redirect        = jump_i | branch_i;
    assign redirect_target = jump_i ? jump_target_i : branch_target_i;
    assign pc4             = pc_plus4(pc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (buf_capture) begin
                buf_q <= imem_rdata_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   if (imem_ready_i && stall_i) state_d = HELD;
                HELD:    if (!stall_i) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    // A redirect outranks everything: the outstanding request is abandoned by moving the address.
    always_comb begin
        imem_req_o  = (state_q == FETCH);
        pc_d        = pc_q;
        buf_capture = 1'b0;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_d      = '{imem_rdata_i, pc4, 1'b1};
        if (redirect) begin
            pc_d       = redirect_target;
            ifid_flush = 1'b1;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready_i && !stall_i) begin
                        ifid_load = 1'b1;
                        pc_d      = pc4;
                    end else if (imem_ready_i && stall_i) begin
                        buf_capture = 1'b1;
                    end else if (!imem_ready_i && !stall_i) begin
                        ifid_flush = 1'b1;
                    end
                end
                HELD: begin
                    if (!stall_i) begin
                        ifid_load = 1'b1;
                        ifid_d    = '{buf_q, pc4, 1'b1};
                        pc_d      = pc4;
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr_o = pc_q;
    assign id_instr_o  = ifid_q.instr;
    assign id_pc4_o    = ifid_q.pc4;
    assign id_valid_o  = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage against a behavioural fetch model
module tb_if_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;

    always #5 clk = ~clk;

    always_comb imem_rdata = imem_addr ^ KEY;

    if_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ready_i    (imem_ready),
        .imem_rdata_i    (imem_rdata),
        .id_instr_o      (id_instr),
        .id_pc4_o        (id_pc4),
        .id_valid_o      (id_valid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: program counter, whether fetching has begun, and an optional parked word.
    logic [31:0] m_pc;
    bit          m_started;
    bit          m_parked;
    logic [31:0] m_parked_word;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    bit          prev_rst_n = 1'b0;

    task automatic check(input string name, input int at, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", name, at, act, exp);
        end
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_pc          = 32'h0;
        m_started     = 1'b0;
        m_parked      = 1'b0;
        m_parked_word = 32'h0;
        model_bubble();
    endtask

    task automatic model_deliver(input logic [31:0] word);
        m_instr = word;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic model_step(input bit st, input bit br, input logic [31:0] bt,
                              input bit jp, input logic [31:0] jt, input bit rdy);
        logic [31:0] word;
        word = m_pc ^ KEY;
        if (jp || br) begin
            m_pc      = jp ? jt : bt;
            m_parked  = 1'b0;
            m_started = 1'b1;
            model_bubble();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_parked) begin
            if (!st) begin
                model_deliver(m_parked_word);
                m_parked = 1'b0;
            end
        end else if (rdy && !st) begin
            model_deliver(word);
        end else if (rdy && st) begin
            m_parked_word = word;
            m_parked      = 1'b1;
        end else if (!rdy && !st) begin
            model_bubble();
        end
    endtask

    task automatic push_exp(input int at);
        exp_t e;
        e.at    = at;
        e.req   = m_started && !m_parked;
        e.addr  = m_pc;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.valid = m_valid;
        sb.push_back(e);
    endtask

    task automatic step(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt, input bit rdy);
        @(posedge clk);
        #1;
        rst_n         = rst;
        stall         = st;
        branch        = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        imem_ready    = rdy;
        if (!rst) begin
            model_reset();
            if (prev_rst_n) begin
                // Asynchronous assertion: outputs must already be at reset values this cycle.
                while (sb.size() > 0 && sb[$].at == cyc) void'(sb.pop_back());
                push_exp(cyc);
            end
            push_exp(cyc + 1);
        end else begin
            model_step(st, br, bt, jp, jt, rdy);
            push_exp(cyc + 1);
        end
        prev_rst_n = rst;
    endtask

    task automatic run(input bit st, input bit rdy);
        step(1'b1, st, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                if (e.at == cyc) begin
                    check("imem_req",  cyc, {31'h0, imem_req}, {31'h0, e.req});
                    check("imem_addr", cyc, imem_addr, e.addr);
                    check("id_instr",  cyc, id_instr,  e.instr);
                    check("id_pc4",    cyc, id_pc4,    e.pc4);
                    check("id_valid",  cyc, {31'h0, id_valid}, {31'h0, e.valid});
                end
            end
        end
    end

    initial begin : stimulus
        bit          st, rdy, br, jp, rs;
        logic [31:0] bt, jt;
        model_reset();

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b0);
        run(1'b0, 1'b0);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b1, 1'b1);
        run(1'b1, 1'b1);
        run(1'b1, 1'b0);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);

        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);

        run(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 19) == 0);
            jp  = ($urandom_range(0, 19) == 0);
            rs  = !($urandom_range(0, 199) == 0);
            bt  = $urandom;
            jt  = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                bt[1:0] = 2'b00;
                jt[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) jt = 32'hFFFF_FFF8;
            step(rs, st, br, bt, jp, jt, rdy);
        end

        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        check("scoreboard_drained", cyc, sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
